// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_pkg: shared constants and types for the register-file write arbiter.
//   XZR_IDX    - index of the zero register; writes to it are accepted but dropped
//   REG_ADDR_W - register index width
//   REG_DATA_W - register data width
//   wb_req_t   - one writeback request (destination index + data)
//   sat_inc    - 16-bit saturating increment used by the optional stats counters
package regfile_pkg;
    localparam int              REG_ADDR_W = 5;
    localparam int              REG_DATA_W = 64;
    localparam logic [4:0]      XZR_IDX    = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: writeback request bus plus register-file write port.
//   req_valid/req_addr/req_data - per-producer requests (producer -> arbiter)
//   req_ready                   - one-hot grant (arbiter -> producer)
//   wr_en/wr_addr/wr_data       - registered write port (arbiter -> register file)
// Modports: slave = arbiter side, master = producers / register-file side.
interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0]             req_ready;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_W-1:0]           wr_data;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter.
//   valid - request vector
//   ptr   - highest-priority index this cycle
//   en    - when low no grant is produced
//   gnt   - one-hot grant (zero when nothing valid or en low)
//   idx   - encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);
    logic          found;
    logic [PW-1:0] j;

    // Scan from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (en && !found && valid[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter and registered write stage for the
// single register-file write port.
//   clk, reset_n - clock, asynchronous active-low reset
//   flush        - drops the pending output write and blocks grants this cycle
//   stall        - register file busy: no grant, output stage holds
//   wb           - request bus and write port (regfile_wr_arbiter_if.slave)
// Optional build macro REGFILE_ARB_STATS_EN adds:
//   grant_cnt    - per-requester saturating 16-bit accepted-transfer counters
//   xzr_drop_cnt - saturating 16-bit count of accepted writes to XZR
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   stall,
    regfile_wr_arbiter_if.slave    wb
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]  grant_cnt,
    output logic [15:0]            xzr_drop_cnt
`endif
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              arb_en;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_xzr;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // reset_n gates the grant so req_ready is zero throughout reset.
    assign arb_en = reset_n & ~stall & ~flush;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .valid (wb.req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    assign wb.req_ready = gnt;
    assign xfer         = |gnt;
    assign win_addr     = wb.req_addr[gnt_idx];
    assign win_data     = wb.req_data[gnt_idx];
    assign win_xzr      = (win_addr == ADDR_W'(XZR_IDX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (flush) begin
            // Flush wins over stall; index/data and ptr hold.
            wr_en_q <= 1'b0;
        end else if (!stall) begin
            if (xfer) begin
                ptr       <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
                wr_en_q   <= ~win_xzr;
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign wb.wr_en   = wr_en_q;
    assign wb.wr_addr = wr_addr_q;
    assign wb.wr_data = wr_data_q;

`ifdef REGFILE_ARB_STATS_EN
    // xfer already implies no stall, no flush and reset released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt    <= '0;
            xzr_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
            if (xfer && win_xzr) xzr_drop_cnt <= sat_inc(xzr_drop_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;
    logic stall   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    wb_req_t tab [NREQ];

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) wb ();

`ifdef REGFILE_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt;
    logic [15:0]           xzr_drop_cnt;
`endif

    regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .stall        (stall),
        .wb           (wb)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .xzr_drop_cnt (xzr_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        wb.req_addr[i] = a;
        wb.req_data[i] = d;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [4:0] a, input logic [63:0] d);
        chk({tag, "_wen"},  64'(wb.wr_en),   64'(en));
        chk({tag, "_addr"}, 64'(wb.wr_addr), 64'(a));
        chk({tag, "_data"}, wb.wr_data,      d);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tab[i].addr = REG_ADDR_W'(i + 1);
            tab[i].data = 64'h100 + 64'(i);
            set_req(i, tab[i].addr, tab[i].data);
        end
        wb.req_valid = 4'hF;

        // Held in reset with traffic present.
        repeat (2) tick();
        chk("rst_ready", 64'(wb.req_ready), 64'h0);
        chk_out("rst", 1'b0, 5'd0, 64'h0);

        // Release: rotation 0,1,2,3,0 with outputs one edge later.
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("rr_ready", 64'(wb.req_ready), 64'(4'b0001 << (c % 4)));
            tick();
            chk_out("rr", 1'b1, 5'((c % 4) + 1), 64'h100 + 64'(c % 4));
        end

        // ptr = 1. Requester 2 writes XZR.
        wb.req_valid = 4'b0100;
        set_req(2, 5'd31, 64'hDEAD);
        #1;
        chk("xzr_ready", 64'(wb.req_ready), 64'h4);
        tick();
        chk_out("xzr", 1'b0, 5'd31, 64'hDEAD);
`ifdef REGFILE_ARB_STATS_EN
        chk("xzr_cnt", 64'(xzr_drop_cnt), 64'h1);
`endif

        // ptr must now be 3: with all valid, requester 3 wins.
        set_req(2, tab[2].addr, tab[2].data);
        wb.req_valid = 4'hF;
        #1;
        chk("ptr3_ready", 64'(wb.req_ready), 64'h8);
        tick();
        chk_out("ptr3", 1'b1, 5'd4, 64'h103);

        // Stall three cycles with 1 and 3 valid; outputs (incl. wr_en=1) hold.
        stall = 1'b1;
        wb.req_valid = 4'b1010;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_ready", 64'(wb.req_ready), 64'h0);
            tick();
            chk_out("stall", 1'b1, 5'd4, 64'h103);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready1", 64'(wb.req_ready), 64'h2);
        tick();
        chk_out("unstall1", 1'b1, 5'd2, 64'h101);
        wb.req_valid = 4'b1000;
        #1;
        chk("unstall_ready3", 64'(wb.req_ready), 64'h8);
        tick();
        chk_out("unstall3", 1'b1, 5'd4, 64'h103);

        // ptr = 0. Grant requester 0 (addr 5), then flush the next cycle.
        set_req(0, 5'd5, 64'h55);
        wb.req_valid = 4'b0001;
        #1;
        chk("fl_grant_ready", 64'(wb.req_ready), 64'h1);
        tick();
        chk_out("fl_grant", 1'b1, 5'd5, 64'h55);
        flush = 1'b1;
        wb.req_valid = 4'b1001;
        #1;
        chk("flush_ready", 64'(wb.req_ready), 64'h0);
        tick();
        chk_out("flush", 1'b0, 5'd5, 64'h55);
        flush = 1'b0;
        #1;
        // ptr held at 1 through the flush, so requester 3 beats requester 0.
        chk("postfl_ready", 64'(wb.req_ready), 64'h8);
        tick();
        chk_out("postfl", 1'b1, 5'd4, 64'h103);

        // No request, stall low: wr_en drops, index/data hold.
        wb.req_valid = 4'b0000;
        tick();
        chk_out("idle", 1'b0, 5'd4, 64'h103);

        // Mid-traffic asynchronous reset.
        set_req(0, tab[0].addr, tab[0].data);
        wb.req_valid = 4'hF;
        tick();
        chk_out("pre_rst", 1'b1, 5'd1, 64'h100);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(wb.req_ready), 64'h0);
        chk_out("mid_rst", 1'b0, 5'd0, 64'h0);
        tick();
        chk("mid_rst_ready2", 64'(wb.req_ready), 64'h0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(wb.req_ready), 64'h1);

`ifdef REGFILE_ARB_STATS_EN
        // Counters cleared by reset; requester 1 alone saturates its counter.
        chk("cnt_rst0", 64'(grant_cnt[0]), 64'h0);
        wb.req_valid = 4'b0010;
        repeat (70000) tick();
        chk("sat_cnt1", 64'(grant_cnt[1]), 64'hFFFF);
        chk("sat_cnt0", 64'(grant_cnt[0]), 64'h0);
        chk("sat_cnt2", 64'(grant_cnt[2]), 64'h0);
        chk("sat_cnt3", 64'(grant_cnt[3]), 64'h0);
        chk("sat_xzr",  64'(xzr_drop_cnt), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
